// File: rtl/uart_mem_bridge_pkg.sv
// Shared encodings for the UART <-> RAM byte-stream engine.
// The legal read-latency range is also used by the memory router.
package uart_mem_bridge_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RX_WAIT  = 3'd1;
    localparam logic [2:0] ST_RX_WRITE = 3'd2;
    localparam logic [2:0] ST_TX_READ  = 3'd3;
    localparam logic [2:0] ST_TX_LAT   = 3'd4;
    localparam logic [2:0] ST_TX_SEND  = 3'd5;
    localparam logic [2:0] ST_TX_WAIT  = 3'd6;
    localparam logic [2:0] ST_FINISH   = 3'd7;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_RX_WAIT  = ST_RX_WAIT,
        S_RX_WRITE = ST_RX_WRITE,
        S_TX_READ  = ST_TX_READ,
        S_TX_LAT   = ST_TX_LAT,
        S_TX_SEND  = ST_TX_SEND,
        S_TX_WAIT  = ST_TX_WAIT,
        S_FINISH   = ST_FINISH
    } state_t;

endpackage

// File: rtl/uart_mem_bridge_xfer_counter.sv
// Base/length/count bookkeeping for one transfer.
// The address is kept as its own register so mem_addr leaves the block registered.
module xfer_counter
    import uart_mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int LEN_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] addr,
    output logic [LEN_W-1:0]  count,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  count_q;
    logic [LEN_W-1:0]  len_q;

    // Latch on start, then step address and count together; address wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= {ADDR_W{1'b0}};
            count_q <= {LEN_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
        end else if (load) begin
            addr_q  <= base;
            count_q <= {LEN_W{1'b0}};
            len_q   <= length;
        end else if (inc) begin
            addr_q  <= addr_q + ADDR_ONE;
            count_q <= count_q + LEN_ONE;
        end
    end

    assign addr  = addr_q;
    assign count = count_q;
    assign last  = ((count_q + LEN_ONE) == len_q);

endmodule

// File: rtl/uart_mem_bridge.sv
// Single DMA engine moving bytes UART->RAM (receive) or RAM->UART (transmit).
// Abort and reset take priority over everything, including a same-cycle start.
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 19,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_rx,
    input  logic              start_tx,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              rx_dv,
    input  logic [DATA_W-1:0] rx_byte,
    output logic              tx_dv,
    output logic [DATA_W-1:0] tx_byte,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [LEN_W-1:0]  xfer_count
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t            state_q;
    logic [1:0]        lat_q;
    logic              tx_dv_q;
    logic [DATA_W-1:0] tx_byte_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              mem_wen_q;
    logic              done_q;
    logic              overrun_q;
    logic              ctr_load_s;
    logic              ctr_inc_s;
    logic              ctr_last_s;

    // Counter control: a write already in flight during abort still counts.
    always_comb begin
        ctr_load_s = (state_q == S_IDLE) && !abort && (start_rx || start_tx);
        ctr_inc_s  = (state_q == S_RX_WRITE) ||
                     ((state_q == S_TX_WAIT) && tx_done && !abort);
    end

    xfer_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_xfer_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (ctr_load_s),
        .inc    (ctr_inc_s),
        .base   (base_addr),
        .length (length),
        .addr   (mem_addr),
        .count  (xfer_count),
        .last   (ctr_last_s)
    );

    // Transfer sequencer with registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lat_q     <= 2'd0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= {DATA_W{1'b0}};
            mem_din_q <= {DATA_W{1'b0}};
            mem_wen_q <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (abort) begin
            state_q   <= S_IDLE;
            tx_dv_q   <= 1'b0;
            mem_wen_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tx_dv_q   <= 1'b0;
            mem_wen_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_rx || start_tx) begin
                        overrun_q <= 1'b0;
                        if (length == {LEN_W{1'b0}}) begin
                            state_q <= S_FINISH;
                        end else if (start_rx) begin
                            state_q <= S_RX_WAIT;
                        end else begin
                            state_q <= S_TX_READ;
                        end
                    end
                end
                S_RX_WAIT: begin
                    if (rx_dv) begin
                        mem_din_q <= rx_byte;
                        mem_wen_q <= 1'b1;
                        state_q   <= S_RX_WRITE;
                    end
                end
                S_RX_WRITE: begin
                    if (rx_dv) begin
                        overrun_q <= 1'b1;
                    end
                    if (ctr_last_s) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        state_q <= S_RX_WAIT;
                    end
                end
                S_TX_READ: begin
                    lat_q   <= 2'd0;
                    state_q <= S_TX_LAT;
                end
                S_TX_LAT: begin
                    if (lat_q == LAT_LAST) begin
                        tx_byte_q <= mem_dout;
                        tx_dv_q   <= 1'b1;
                        state_q   <= S_TX_SEND;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                S_TX_SEND: begin
                    state_q <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (tx_done) begin
                        if (ctr_last_s) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            state_q <= S_TX_READ;
                        end
                    end
                end
                S_FINISH: begin
                    // Zero-length entry arrives without done set; raise it here for one cycle.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign tx_dv   = tx_dv_q;
    assign tx_byte = tx_byte_q;
    assign mem_din = mem_din_q;
    assign mem_wen = mem_wen_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge with a behavioural RAM of read latency 2.
module tb_uart_mem_bridge;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 19;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_rx = 1'b0;
    logic              start_tx = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              rx_dv = 1'b0;
    logic [DATA_W-1:0] rx_byte = '0;
    logic              tx_dv;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_done = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [LEN_W-1:0]  xfer_count;

    uart_mem_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_rx   (start_rx),
        .start_tx   (start_tx),
        .abort      (abort),
        .base_addr  (base_addr),
        .length     (length),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_wen    (mem_wen),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // RAM model, write log and pulse counters
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] dout_r;
    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    int                done_cnt = 0;
    int                txdv_cnt = 0;

    always @(posedge clk) begin
        if (mem_wen) begin
            ram[mem_addr] = mem_din;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_din);
        end
        if (done) done_cnt = done_cnt + 1;
        if (tx_dv) txdv_cnt = txdv_cnt + 1;
        rd1    <= ram[mem_addr];
        dout_r <= rd1;
    end
    assign mem_dout = dout_r;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit rx, input bit tx, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
        base_addr = b;
        length    = n;
        start_rx  = rx;
        start_tx  = tx;
        tick();
        start_rx  = 1'b0;
        start_tx  = 1'b0;
    endtask

    task automatic send_rx(input logic [DATA_W-1:0] b, input logic [ADDR_W-1:0] exp_addr);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        chk("rx_wen", 32'(mem_wen), 32'd1);
        chk("rx_addr", 32'(mem_addr), 32'(exp_addr));
        chk("rx_din", 32'(mem_din), 32'(b));
        tick();
    endtask

    task automatic chk_writes(input string tag, input int from, input int n,
                              input logic [ADDR_W-1:0] ea [4], input logic [DATA_W-1:0] ed [4]);
        chk({tag, "_nwr"}, 32'(wa_q.size() - from), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (from + i < wa_q.size()) begin
                chk({tag, "_wa"}, 32'(wa_q[from+i]), 32'(ea[i]));
                chk({tag, "_wd"}, 32'(wd_q[from+i]), 32'(ed[i]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, t0, k;
        logic [ADDR_W-1:0] ea [4];
        logic [DATA_W-1:0] ed [4];
        logic [DATA_W-1:0] txe [3];

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_txdv", 32'(tx_dv), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_cnt", 32'(xfer_count), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);

        // Receive 4 bytes to 0x10
        w0 = wa_q.size(); d0 = done_cnt;
        start(1'b1, 1'b0, 18'h00010, 19'd4);
        chk("rx4_busy", 32'(busy), 32'd1);
        ea = '{18'h10, 18'h11, 18'h12, 18'h13};
        ed = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) send_rx(ed[i], ea[i]);
        chk("rx4_done", 32'(done), 32'd1);
        tick();
        chk("rx4_idle", 32'(busy), 32'd0);
        chk("rx4_cnt", 32'(xfer_count), 32'd4);
        chk("rx4_ndone", 32'(done_cnt - d0), 32'd1);
        chk_writes("rx4", w0, 4, ea, ed);

        // Preload 11,22,33 at 0x20 through the receive path
        start(1'b1, 1'b0, 18'h00020, 19'd3);
        send_rx(8'h11, 18'h20); send_rx(8'h22, 18'h21); send_rx(8'h33, 18'h22);
        tick();

        // Transmit with read latency 2
        txe = '{8'h11, 8'h22, 8'h33};
        d0 = done_cnt;
        start(1'b0, 1'b1, 18'h00020, 19'd3);
        chk("tx_addr0", 32'(mem_addr), 32'h20);
        k = 1;
        while (!tx_dv && k < 20) begin tick(); k++; end
        chk("tx_first_lat", 32'(k), 32'd4);
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (!tx_dv && k < 20) begin tick(); k++; end
            chk("tx_dv", 32'(tx_dv), 32'd1);
            chk("tx_byte", 32'(tx_byte), 32'(txe[i]));
            tick(); tick();
            chk("tx_dv_low", 32'(tx_dv), 32'd0);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (i < 2) chk("tx_next_addr", 32'(mem_addr), 32'h21 + 32'(i));
            else       chk("tx_done", 32'(done), 32'd1);
        end
        tick();
        chk("tx_idle", 32'(busy), 32'd0);
        chk("tx_cnt", 32'(xfer_count), 32'd3);
        chk("tx_ndone", 32'(done_cnt - d0), 32'd1);

        // Wrap-around
        w0 = wa_q.size();
        start(1'b1, 1'b0, 18'h3FFFF, 19'd3);
        ea = '{18'h3FFFF, 18'h00000, 18'h00001, 18'h0};
        ed = '{8'h01, 8'h02, 8'h03, 8'h00};
        for (int i = 0; i < 3; i++) send_rx(ed[i], ea[i]);
        tick();
        chk_writes("wrap", w0, 3, ea, ed);

        // Overrun: back-to-back rx_dv drops the second byte
        w0 = wa_q.size();
        start(1'b1, 1'b0, 18'h00100, 19'd2);
        rx_dv = 1'b1; rx_byte = 8'hAA;
        tick();
        rx_byte = 8'hBB;
        tick();
        rx_dv = 1'b0;
        chk("ovr_set", 32'(overrun), 32'd1);
        send_rx(8'hCC, 18'h101);
        tick();
        chk("ovr_sticky", 32'(overrun), 32'd1);
        ea = '{18'h100, 18'h101, 18'h0, 18'h0};
        ed = '{8'hAA, 8'hCC, 8'h00, 8'h00};
        chk_writes("ovr", w0, 2, ea, ed);
        start(1'b1, 1'b0, 18'h00200, 19'd1);
        chk("ovr_clr", 32'(overrun), 32'd0);
        send_rx(8'h44, 18'h200);
        tick();

        // Zero length
        w0 = wa_q.size(); d0 = done_cnt; t0 = txdv_cnt;
        start(1'b0, 1'b1, 18'h00300, 19'd0);
        chk("z_busy", 32'(busy), 32'd1);
        chk("z_done_c1", 32'(done), 32'd0);
        tick();
        chk("z_done_c2", 32'(done), 32'd1);
        tick();
        chk("z_idle", 32'(busy), 32'd0);
        chk("z_nwr", 32'(wa_q.size() - w0), 32'd0);
        chk("z_ntx", 32'(txdv_cnt - t0), 32'd0);
        chk("z_ndone", 32'(done_cnt - d0), 32'd1);

        // Both starts: receive wins; a later start_tx is ignored while busy
        w0 = wa_q.size(); t0 = txdv_cnt;
        start(1'b1, 1'b1, 18'h00300, 19'd1);
        start(1'b0, 1'b1, 18'h00555, 19'd2);
        tick(); tick();
        chk("conf_addr", 32'(mem_addr), 32'h300);
        send_rx(8'h77, 18'h300);
        tick();
        chk("conf_ntx", 32'(txdv_cnt - t0), 32'd0);
        chk("conf_nwr", 32'(wa_q.size() - w0), 32'd1);
        chk("conf_idle", 32'(busy), 32'd0);

        // Abort or reset together with a start drops the start
        abort = 1'b1; start(1'b1, 1'b0, 18'h0, 19'd2); abort = 1'b0;
        chk("abort_start", 32'(busy), 32'd0);
        rst = 1'b1; start(1'b0, 1'b1, 18'h0, 19'd2); rst = 1'b0;
        chk("rst_start", 32'(busy), 32'd0);

        // Abort after 2 of 5 bytes
        d0 = done_cnt;
        start(1'b1, 1'b0, 18'h00400, 19'd5);
        send_rx(8'h01, 18'h400); send_rx(8'h02, 18'h401);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle", 32'(busy), 32'd0);
        tick(); tick();
        chk("ab_cnt", 32'(xfer_count), 32'd2);
        chk("ab_ndone", 32'(done_cnt - d0), 32'd0);

        // Reset mid-transmit
        start(1'b0, 1'b1, 18'h00020, 19'd3);
        tick(); tick(); tick();
        chk("rtx_dv", 32'(tx_dv), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rtx_busy", 32'(busy), 32'd0);
        chk("rtx_txdv", 32'(tx_dv), 32'd0);
        chk("rtx_byte", 32'(tx_byte), 32'd0);
        chk("rtx_addr", 32'(mem_addr), 32'd0);
        chk("rtx_din", 32'(mem_din), 32'd0);
        chk("rtx_cnt", 32'(xfer_count), 32'd0);
        chk("rtx_ovr", 32'(overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
